game_state_hist: RTL
====================

# game_state_hist

Write-side counterpart of the game-state 4:1 selector. Holds four N-bit game-state slots as a ring-buffer move history. It writes each new state into the next slot and drives the slot select, so the existing selector outputs the current state. Supports level load, move push and undo of up to three moves, with one-cycle acknowledge pulses and a saturating move counter.

## Interface

Parameters:
- N, 134, width of one packed game state
- CW, 16, width of move counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  start level: history cleared, init_state written to slot 0
- init_state  input  N  level start state, sampled when load accepted
- push  input  1  commit one move; new_state written to next slot
- new_state  input  N  post-move state, sampled when push accepted
- undo  input  1  step back one move
- st_0, st_1, st_2, st_3  output  N each  slot registers, wired to selector in_0..in_3
- sel  output  2  index of current slot, wired to selector sel
- depth  output  2  undoable moves available, 0..3
- can_undo  output  1  depth != 0, combinational from depth
- push_ack  output  1  one-cycle pulse: push accepted
- undo_ack  output  1  one-cycle pulse: undo accepted
- undo_err  output  1  one-cycle pulse: undo rejected (depth was 0)
- moves  output  CW  net move count, saturating

## Operation

- Requests are sampled every rising edge; no ready handshake, every cycle accepts.
- Priority per cycle: rst > load > push > undo. A lower-priority request in the same cycle is dropped silently, with no ack and no err.
- rst: st_0..st_3 = 0, sel = 0, depth = 0, moves = 0, all pulses 0.
- load: st_0 <= init_state, sel <= 0, depth <= 0, moves <= 0. Other slots are unchanged. No ack pulse.
- push: slot[sel+1 mod 4] <= new_state, sel <= sel+1 mod 4, depth <= min(depth+1, 3), moves <= moves+1 saturating at 2^CW-1, push_ack <= 1.
  - When depth is already 3, the oldest entry is overwritten and depth stays 3.
- undo with depth > 0: sel <= sel-1 mod 4, depth <= depth-1, moves <= moves-1 (moves is never decremented below 0), undo_ack <= 1. Slot contents are unchanged.
- undo with depth = 0: no state change, undo_err <= 1.
- Slots are written only by load (slot 0) or push (slot sel+1). No other write paths.
- Redo is not supported. A push after an undo discards the undone future.
- Pulses are registered and are 0 in every cycle without the corresponding event. Back-to-back requests give back-to-back pulses.

## Timing

- Request sampled at edge k. Slots, sel, depth and moves update at edge k. The pulse is high for cycle k..k+1.
- Current state, seen through the selector, is valid the cycle after the request. It is combinational through the mux from registered sel and slots.
- Throughput is one push or one undo per cycle.
- rst asserted during any operation takes effect at that edge and overrides every request.
- Wrap-around: sel goes 3 to 0 on push and 0 to 3 on undo. No special cases.
- Reset values: all outputs 0. can_undo = 0.

## Test plan

- Reset, then load init_state=A: sel=0, st_0=A, depth=0, moves=0, can_undo=0; no pulses.
- load A, push B, C, D, E on consecutive cycles: sel sequence 1,2,3,0, st_0=E, depth saturates 3, moves=4, push_ack high 4 consecutive cycles.
- Continuing, undo ×3: sel 3,2,1, current state D, C, B, depth 0, moves=1, three undo_ack pulses. Fourth undo: undo_err=1, sel=1, moves=1.
- Same-cycle push+undo with sel=2, depth=2: push wins, sel=3, depth=3, push_ack=1, undo_ack=0, undo_err=0. Same-cycle load+push: load wins, sel=0, st_0=init_state.
- CW=4: 16 pushes then undo: moves saturates at 15 then goes to 14. rst mid-sequence: all outputs 0 next cycle.
- load A, push B, undo, push C: st_1=C, sel=1, depth=1, moves=1. B is lost and there is no redo.

Source files
------------

// File: rtl/game_state_hist.sv
// game_state_hist: four-slot ring-buffer move history feeding the
// game-state 4:1 selector; level load, move push and bounded undo.
module game_state_hist #(
    parameter int N  = 134,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [N-1:0]  init_state,
    input  logic          push,
    input  logic [N-1:0]  new_state,
    input  logic          undo,
    output logic [N-1:0]  st_0,
    output logic [N-1:0]  st_1,
    output logic [N-1:0]  st_2,
    output logic [N-1:0]  st_3,
    output logic [1:0]    sel,
    output logic [1:0]    depth,
    output logic          can_undo,
    output logic          push_ack,
    output logic          undo_ack,
    output logic          undo_err,
    output logic [CW-1:0] moves
);

    logic [N-1:0] slot [4];
    logic [1:0]   sel_nxt;
    logic [1:0]   sel_prv;

    assign sel_nxt  = sel + 2'd1;
    assign sel_prv  = sel - 2'd1;
    assign st_0     = slot[0];
    assign st_1     = slot[1];
    assign st_2     = slot[2];
    assign st_3     = slot[3];
    assign can_undo = (depth != 2'd0);

    // Priority rst > load > push > undo; losers are dropped silently.
    always_ff @(posedge clk) begin
        push_ack <= 1'b0;
        undo_ack <= 1'b0;
        undo_err <= 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                slot[i] <= '0;
            end
            sel   <= 2'd0;
            depth <= 2'd0;
            moves <= '0;
        end else if (load) begin
            slot[0] <= init_state;
            sel     <= 2'd0;
            depth   <= 2'd0;
            moves   <= '0;
        end else if (push) begin
            slot[sel_nxt] <= new_state;
            sel           <= sel_nxt;
            push_ack      <= 1'b1;
            if (depth != 2'd3) begin
                depth <= depth + 2'd1;
            end
            if (moves != '1) begin
                moves <= moves + CW'(1);
            end
        end else if (undo) begin
            if (depth != 2'd0) begin
                sel      <= sel_prv;
                depth    <= depth - 2'd1;
                undo_ack <= 1'b1;
                if (moves != '0) begin
                    moves <= moves - CW'(1);
                end
            end else begin
                undo_err <= 1'b1;
            end
        end
    end

endmodule
